// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C slave byte engines (write and read flavours).
// Contents:
//   i2c_state_e      - FSM state encodings of the byte engines
//   I2C_ACK/I2C_NACK - values reported on the ack output
//   HOLD_CYCLES_MAX  - largest supported SDA hold time in clocks
//   HOLD_CNT_W       - width of the hold counter
//   ack_from_sda()   - decode a sampled ACK-slot SDA level
// ---------------------------------------------------------------------------
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_WAIT_LOW  = 4'd1,
      ST_HOLD      = 4'd2,
      ST_WAIT_RISE = 4'd3,
      ST_WAIT_FALL = 4'd4,
      ST_ACK_HOLD  = 4'd5,
      ST_ACK_RISE  = 4'd6,
      ST_ACK_FALL  = 4'd7,
      ST_DONE      = 4'd8
   } i2c_state_e;

   localparam logic I2C_ACK  = 1'b1;
   localparam logic I2C_NACK = 1'b0;

   localparam int unsigned HOLD_CYCLES_MAX = 15;
   localparam int unsigned HOLD_CNT_W      = 4;

   // A master acknowledges by pulling SDA low during the ninth clock.
   function automatic logic ack_from_sda(input logic sda_level);
      return sda_level ? I2C_NACK : I2C_ACK;
   endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// ---------------------------------------------------------------------------
// i2c_sync_edge
// Two-flop synchronizer for a raw bus line followed by an edge detector.
// Ports:
//   clock - system clock, rising edge
//   reset - synchronous, active-high; flops go to 1 (released bus)
//   in    - raw asynchronous bus level
//   level - synchronized level, registered in step with rise/fall
//   rise  - one-cycle pulse on a 0->1 change of the synchronized level
//   fall  - one-cycle pulse on a 1->0 change of the synchronized level
// ---------------------------------------------------------------------------
module i2c_sync_edge (
   input  logic clock,
   input  logic reset,
   input  logic in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q,  meta_d;
   logic sync_q,  sync_d;
   logic level_q, level_d;
   logic rise_q,  rise_d;
   logic fall_q,  fall_d;

   // level_q is the previous synchronized value; it is updated on the same
   // edge as rise_q/fall_q so the three outputs always describe one instant.
   always_comb begin
      meta_d  = in;
      sync_d  = meta_q;
      level_d = sync_q;
      rise_d  = sync_q & ~level_q;
      fall_d  = ~sync_q & level_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q  <= 1'b1;
         sync_q  <= 1'b1;
         level_q <= 1'b1;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

// File: rtl/i2c_slave_write_byte.sv
// ---------------------------------------------------------------------------
// i2c_slave_write_byte
// Slave-side transmitter of one byte on I2C (the master reads): shifts the
// byte out MSB first on open-drain SDA, then samples the master's ACK.
// Parameters:
//   HOLD_CYCLES   - clocks from a detected SCL fall to the SDA update (1..15)
// Ports:
//   clock         - system clock, rising edge
//   reset         - synchronous, active-high
//   go            - start request, honoured only when idle
//   data[7:0]     - byte to send, captured with an accepted go
//   abort         - bus START/STOP seen upstream; drop the transfer
//   scl, sda      - raw bus levels
//   sda_drive_low - 1 pulls SDA low, 0 releases it
//   finish        - one-cycle pulse after the ACK slot completes
//   ack           - 1 when the master acknowledged; held until the next go
//   busy          - high whenever the engine is not idle
// ---------------------------------------------------------------------------
module i2c_slave_write_byte
   import i2c_pkg::*;
#(
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       go,
   input  logic [7:0] data,
   input  logic       abort,
   input  logic       scl,
   input  logic       sda,
   output logic       sda_drive_low,
   output logic       finish,
   output logic       ack,
   output logic       busy
);

   // Out-of-range values are clamped so the hold counter can never wrap.
   localparam int unsigned HOLD_CLAMP =
      (HOLD_CYCLES < 1) ? 1 :
      (HOLD_CYCLES > HOLD_CYCLES_MAX) ? HOLD_CYCLES_MAX : HOLD_CYCLES;
   localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(HOLD_CLAMP - 1);

   i2c_state_e            state_q,    state_d;
   logic [7:0]            shift_q,    shift_d;
   logic [2:0]            bit_cnt_q,  bit_cnt_d;
   logic [HOLD_CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic                  sda_q,      sda_d;
   logic                  ack_q,      ack_d;

   logic scl_level, scl_rise, scl_fall;
   logic sda_level, sda_rise_unused, sda_fall_unused;

   i2c_sync_edge u_scl_sync (
      .clock (clock),
      .reset (reset),
      .in    (scl),
      .level (scl_level),
      .rise  (scl_rise),
      .fall  (scl_fall)
   );

   i2c_sync_edge u_sda_sync (
      .clock (clock),
      .reset (reset),
      .in    (sda),
      .level (sda_level),
      .rise  (sda_rise_unused),
      .fall  (sda_fall_unused)
   );

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_cnt_d  = bit_cnt_q;
      hold_cnt_d = hold_cnt_q;
      sda_d      = sda_q;
      ack_d      = ack_q;

      if (abort && (state_q != ST_IDLE)) begin
         state_d    = ST_IDLE;
         sda_d      = 1'b0;
         hold_cnt_d = '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (go && !abort) begin
                  shift_d   = data;
                  bit_cnt_d = 3'd7;
                  ack_d     = 1'b0;
                  state_d   = ST_WAIT_LOW;
               end
            end
            // level drops in the same cycle the fall pulse appears, so this
            // covers both an already-low SCL and a pending falling edge.
            ST_WAIT_LOW: begin
               if (!scl_level) begin
                  hold_cnt_d = '0;
                  state_d    = ST_HOLD;
               end
            end
            // sda_q keeps the previous bit until the hold time has elapsed.
            ST_HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  sda_d   = ~shift_q[7];
                  state_d = ST_WAIT_RISE;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            ST_WAIT_RISE: begin
               if (scl_rise) begin
                  state_d = ST_WAIT_FALL;
               end
            end
            ST_WAIT_FALL: begin
               if (scl_fall) begin
                  hold_cnt_d = '0;
                  if (bit_cnt_q == 3'd0) begin
                     state_d = ST_ACK_HOLD;
                  end else begin
                     shift_d   = {shift_q[6:0], 1'b0};
                     bit_cnt_d = bit_cnt_q - 3'd1;
                     state_d   = ST_HOLD;
                  end
               end
            end
            ST_ACK_HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  sda_d   = 1'b0;
                  state_d = ST_ACK_RISE;
               end else begin
                  hold_cnt_d = hold_cnt_q + 1'b1;
               end
            end
            ST_ACK_RISE: begin
               if (scl_rise) begin
                  ack_d   = ack_from_sda(sda_level);
                  state_d = ST_ACK_FALL;
               end
            end
            ST_ACK_FALL: begin
               if (scl_fall) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: begin
               sda_d   = 1'b0;
               state_d = ST_IDLE;
            end
            default: begin
               sda_d   = 1'b0;
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         hold_cnt_q <= '0;
         sda_q      <= 1'b0;
         ack_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_cnt_q  <= bit_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         sda_q      <= sda_d;
         ack_q      <= ack_d;
      end
   end

   assign sda_drive_low = sda_q;
   assign finish        = (state_q == ST_DONE);
   assign ack           = ack_q;
   assign busy          = (state_q != ST_IDLE);

endmodule
